// File: rtl/fetch_buffered.sv
// Instruction fetch unit: credit-gated sequential requests tagged with a redirect
// epoch, in-order responses buffered in a small FIFO ahead of decode.
module fetch_buffered #(
  parameter int                     p_addr_bits     = 32,
  parameter logic [p_addr_bits-1:0] p_rst_addr      = '0,
  parameter int                     p_inst_bits     = 32,
  parameter int                     p_opaq_bits     = 8,
  parameter int                     p_max_in_flight = 4,
  parameter int                     p_buf_depth     = 4,
  parameter int                     p_inst_bytes    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_addr_bits-1:0] mem_req_addr,
  output logic [p_opaq_bits-1:0] mem_req_opaque,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_opaq_bits-1:0] mem_resp_opaque,
  input  logic [p_addr_bits-1:0] mem_resp_addr,
  input  logic [p_inst_bits-1:0] mem_resp_data,
  output logic                   d_val,
  input  logic                   d_rdy,
  output logic [p_inst_bits-1:0] d_inst,
  output logic [p_addr_bits-1:0] d_pc,
  input  logic                   redirect_val,
  input  logic [p_addr_bits-1:0] redirect_target
);

  localparam int IF_W  = $clog2(p_max_in_flight + 1);
  localparam int CNT_W = $clog2(p_buf_depth + 1);
  localparam int PTR_W = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;

  localparam logic [p_addr_bits-1:0] ADDR_INC  = p_addr_bits'(p_inst_bytes);
  localparam logic [p_opaq_bits-1:0] EPOCH_ONE = p_opaq_bits'(1);
  localparam logic [IF_W-1:0]        IF_ONE    = IF_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]       PTR_LAST  = PTR_W'(p_buf_depth - 1);

  // An epoch must never come back round while a request tagged with it is outstanding.
  generate
    if ((p_opaq_bits < 31) && ((1 << p_opaq_bits) <= p_max_in_flight)) begin : g_bad_opaq
      $error("fetch_buffered: 2**p_opaq_bits must exceed p_max_in_flight");
    end
    if (p_buf_depth < 1) begin : g_bad_depth
      $error("fetch_buffered: p_buf_depth must be at least 1");
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  logic [p_addr_bits-1:0] pc_q, pc_d;
  logic [p_opaq_bits-1:0] epoch_q, epoch_d, epoch_nxt;
  logic [IF_W-1:0]        in_flight_q, in_flight_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [p_inst_bits-1:0] buf_inst_q [p_buf_depth];
  logic [p_addr_bits-1:0] buf_pc_q   [p_buf_depth];

  logic credit_ok, req_xfer, resp_xfer, enq, deq;

  always_comb begin
    // Reserving a FIFO slot per outstanding request lets the response port never stall.
    credit_ok = (int'(in_flight_q) < p_max_in_flight) &&
                (int'(in_flight_q) + int'(count_q) < p_buf_depth);
    mem_req_val    = rst && credit_ok;
    mem_req_addr   = redirect_val ? redirect_target : pc_q;
    epoch_nxt      = epoch_q + EPOCH_ONE;
    mem_req_opaque = redirect_val ? epoch_nxt : epoch_q;
    mem_resp_rdy   = 1'b1;
    req_xfer       = mem_req_val && mem_req_rdy;
    resp_xfer      = mem_resp_val;
    enq            = resp_xfer && (mem_resp_opaque == epoch_q) && !redirect_val;
    d_val          = rst && (count_q != '0) && !redirect_val;
    deq            = d_val && d_rdy;
    d_inst         = buf_inst_q[rd_ptr_q];
    d_pc           = buf_pc_q[rd_ptr_q];
  end

  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    in_flight_d = in_flight_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (req_xfer) begin
      pc_d = mem_req_addr + ADDR_INC;
    end else if (redirect_val) begin
      pc_d = redirect_target;
    end

    unique case ({req_xfer, resp_xfer})
      2'b10:   in_flight_d = in_flight_q + IF_ONE;
      2'b01:   in_flight_d = in_flight_q - IF_ONE;
      default: in_flight_d = in_flight_q;
    endcase

    if (redirect_val) begin
      epoch_d  = epoch_nxt;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= p_rst_addr;
      epoch_q     <= '0;
      in_flight_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Buffer contents carry no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_inst_q[wr_ptr_q] <= mem_resp_data;
      buf_pc_q[wr_ptr_q]   <= mem_resp_addr;
    end
  end

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered: a 1-cycle in-order memory model with a
// response hold switch, and a decode-side capture of every delivered instruction.
module tb_fetch_buffered;

  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_val, mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [2:0]  mem_req_opaque;
  logic        mem_resp_val = 1'b0;
  logic        mem_resp_rdy;
  logic [2:0]  mem_resp_opaque = '0;
  logic [31:0] mem_resp_addr = '0;
  logic [31:0] mem_resp_data = '0;
  logic        d_val, d_rdy;
  logic [31:0] d_inst, d_pc;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        hold;

  int vectors = 0;
  int miscompares = 0;
  int issued = 0;
  int delivered = 0;
  int cyc = 0;

  logic [34:0] mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];

  fetch_buffered #(
    .p_addr_bits    (32),
    .p_rst_addr     (32'h200),
    .p_inst_bits    (32),
    .p_opaq_bits    (3),
    .p_max_in_flight(4),
    .p_buf_depth    (4),
    .p_inst_bytes   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_val    (mem_req_val),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_addr   (mem_req_addr),
    .mem_req_opaque (mem_req_opaque),
    .mem_resp_val   (mem_resp_val),
    .mem_resp_rdy   (mem_resp_rdy),
    .mem_resp_opaque(mem_resp_opaque),
    .mem_resp_addr  (mem_resp_addr),
    .mem_resp_data  (mem_resp_data),
    .d_val          (d_val),
    .d_rdy          (d_rdy),
    .d_inst         (d_inst),
    .d_pc           (d_pc),
    .redirect_val   (redirect_val),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  // Memory: accepts a request at one edge, presents its response until the next.
  always @(posedge clk) begin
    logic [34:0] head;
    if (!rst) begin
      mq.delete();
      mem_resp_val <= 1'b0;
    end else begin
      if (mem_resp_val) void'(mq.pop_front());
      if (mem_req_val && mem_req_rdy) begin
        mq.push_back({mem_req_opaque, mem_req_addr});
        issued++;
      end
      if (!hold && mq.size() > 0) begin
        head = mq[0];
        mem_resp_val    <= 1'b1;
        mem_resp_opaque <= head[34:32];
        mem_resp_addr   <= head[31:0];
        mem_resp_data   <= head[31:0] ^ DATA_KEY;
      end else begin
        mem_resp_val <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst && d_val && d_rdy) begin
      got_pc.push_back(d_pc);
      got_inst.push_back(d_inst);
      got_cyc.push_back(cyc);
      delivered++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    return (i < got_inst.size()) ? got_inst[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [2:0] wrap_op [8];
    wrap_op = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};

    rst = 1'b0; mem_req_rdy = 1'b1; d_rdy = 1'b1;
    redirect_val = 1'b0; redirect_target = '0; hold = 1'b0;

    // reset state
    cycles(2); #1;
    check("rst_req_val",  32'(mem_req_val),  32'd0);
    check("rst_d_val",    32'(d_val),        32'd0);
    check("rst_resp_rdy", 32'(mem_resp_rdy), 32'd1);
    rst = 1'b1; #1;
    check("first_addr",   mem_req_addr,        32'h200);
    check("first_opaque", 32'(mem_req_opaque), 32'd0);
    check("first_val",    32'(mem_req_val),    32'd1);

    // streaming from 0x200, one instruction per cycle
    cycles(12);
    check("stream_count", 32'(got_pc.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("stream_pc",   pc_at(i),   32'h200 + 32'(4 * i));
      check("stream_inst", inst_at(i), (32'h200 + 32'(4 * i)) ^ DATA_KEY);
    end
    check("stream_gap", 32'(cyc_at(7) - cyc_at(0)), 32'd7);

    // decode backpressure
    d_rdy = 1'b0;
    cycles(20); #1;
    check("bp_req_val",     32'(mem_req_val),        32'd0);
    check("bp_outstanding", 32'(issued - delivered), 32'd4);
    d_rdy = 1'b1;
    cycles(10);
    mem_req_rdy = 1'b0; #1;
    check("req_val_ignores_rdy", 32'(mem_req_val), 32'd1);
    cycles(8);
    check("bp_no_loss", 32'(delivered), 32'(issued));
    for (int i = 0; i < got_pc.size(); i++) begin
      check("bp_order_pc", pc_at(i), 32'h200 + 32'(4 * i));
    end

    // three epoch-0 requests held in memory, then redirect to 0x1000
    hold = 1'b1; mem_req_rdy = 1'b1;
    cycles(3);
    base = got_pc.size();
    redirect_val = 1'b1; redirect_target = 32'h1000; hold = 1'b0; #1;
    check("redir_addr",   mem_req_addr,        32'h1000);
    check("redir_opaque", 32'(mem_req_opaque), 32'd1);
    check("redir_val",    32'(mem_req_val),    32'd1);
    check("redir_d_val",  32'(d_val),          32'd0);
    cycles(1);
    redirect_val = 1'b0;
    cycles(20);
    for (int i = 0; i < 4; i++) begin
      check("redir_pc", pc_at(base + i), 32'h1000 + 32'(4 * i));
    end
    check("redir_inst", inst_at(base), 32'h1000 ^ DATA_KEY);

    // back-to-back redirects while streaming
    base = got_pc.size();
    redirect_val = 1'b1; redirect_target = 32'h40; #1;
    check("b2b_op1",   32'(mem_req_opaque), 32'd2);
    check("b2b_d_val", 32'(d_val),          32'd0);
    cycles(1);
    redirect_target = 32'h80; #1;
    check("b2b_addr2", mem_req_addr,        32'h80);
    check("b2b_op2",   32'(mem_req_opaque), 32'd3);
    cycles(1);
    redirect_val = 1'b0;
    cycles(20);
    for (int i = 0; i < 3; i++) begin
      check("b2b_pc", pc_at(base + i), 32'h80 + 32'(4 * i));
    end
    check("b2b_inst", inst_at(base), 32'h80 ^ DATA_KEY);

    // eight consecutive redirects: epoch 3 wraps through 7 -> 0 back to 3
    base = got_pc.size();
    for (int k = 0; k < 8; k++) begin
      redirect_val = 1'b1; redirect_target = 32'h3000 + 32'(k * 32'h100); #1;
      check("wrap_opaque", 32'(mem_req_opaque), 32'(wrap_op[k]));
      cycles(1);
    end
    redirect_val = 1'b0;
    cycles(25);
    for (int i = 0; i < 3; i++) begin
      check("wrap_pc", pc_at(base + i), 32'h3700 + 32'(4 * i));
    end

    // reset with a full FIFO
    d_rdy = 1'b0;
    cycles(12); #1;
    check("pre_rst_d_val",   32'(d_val),       32'd1);
    check("pre_rst_req_val", 32'(mem_req_val), 32'd0);
    rst = 1'b0;
    cycles(1); #1;
    check("mid_rst_d_val",   32'(d_val),       32'd0);
    check("mid_rst_req_val", 32'(mem_req_val), 32'd0);
    cycles(1);
    rst = 1'b1; d_rdy = 1'b1;
    base = got_pc.size(); #1;
    check("restart_addr",   mem_req_addr,        32'h200);
    check("restart_opaque", 32'(mem_req_opaque), 32'd0);
    check("restart_val",    32'(mem_req_val),    32'd1);
    cycles(10);
    check("restart_pc0", pc_at(base),     32'h200);
    check("restart_pc1", pc_at(base + 1), 32'h204);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
